// File: rtl/spi_tx_master_if.sv
// -----------------------------------------------------------------------------
// spi_tx_master_if
// Purpose : groups the FIFO read-side handshake and the SPI pin signals of
//           spi_tx_master into one bundle.
// Signals : enable      - permits starting new frames
//           fifo_empty  - FIFO empty flag
//           fifo_data   - FIFO head word, valid whenever fifo_empty=0
//           fifo_read   - one-cycle pop strobe to the FIFO
//           sclk        - serial clock, idle low
//           mosi        - serial data, changes on sclk falling edge
//           cs_n        - chip select, active low
//           busy        - transmitter not idle
//           done        - one-cycle pulse when a frame completes
// Modports: master (the transmitter), slave (the FIFO/pin side).
// -----------------------------------------------------------------------------
interface spi_tx_master_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_read;
    logic                  sclk;
    logic                  mosi;
    logic                  cs_n;
    logic                  busy;
    logic                  done;

    modport master (
        input  enable, fifo_empty, fifo_data,
        output fifo_read, sclk, mosi, cs_n, busy, done
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  fifo_read, sclk, mosi, cs_n, busy, done
    );
endinterface

// File: rtl/spi_tx_master.sv
// -----------------------------------------------------------------------------
// spi_tx_master
// Purpose : SPI mode-0 transmitter. Pops one word from the TX FIFO whenever
//           the FIFO is non-empty and transmission is enabled, then shifts it
//           out MSB-first on SCLK/MOSI while CS_N is low.
// Ports   : i_clk   - system clock, rising edge
//           i_rst_n - asynchronous active-low reset
//           bus     - spi_tx_master_if.master (enable, FIFO read port, pins,
//                     busy/done status)
// -----------------------------------------------------------------------------
module spi_tx_master #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    spi_tx_master_if.master bus
);

    localparam int CNT_W = 16;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = 16'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bitcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_fifo_read;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_div_end;
    logic                  w_gap_end;

    assign w_div_end = (r_cnt == DIV_LAST);
    assign w_gap_end = (r_cnt == GAP_LAST);

    assign bus.fifo_read = r_fifo_read;
    assign bus.sclk      = r_sclk;
    assign bus.mosi      = r_mosi;
    assign bus.cs_n      = r_cs_n;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.enable && !bus.fifo_empty) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_SETUP;
            S_SETUP: if (w_div_end) w_next_state = S_SHIFT;
            // The frame ends once the low phase after the last bit expires.
            S_SHIFT: if (w_div_end && !r_sclk && (r_bitcnt == BIT_LAST)) w_next_state = S_GAP;
            S_GAP:   if (w_gap_end) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_fifo_read <= 1'b0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != S_IDLE);
            r_fifo_read <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_next_state == S_LOAD) begin
                        r_shift     <= bus.fifo_data;
                        r_fifo_read <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_cs_n <= 1'b0;
                    r_mosi <= r_shift[DATA_WIDTH-1];
                    r_cnt  <= '0;
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_cnt    <= '0;
                        r_sclk   <= 1'b1;
                        r_bitcnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_cnt <= '0;
                        if (r_sclk) begin
                            // Falling edge: present the next lower bit. After the
                            // last bit the zero fill drives MOSI low.
                            r_sclk   <= 1'b0;
                            r_shift  <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                            r_mosi   <= r_shift[DATA_WIDTH-2];
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end else if (w_next_state == S_GAP) begin
                            r_cs_n <= 1'b1;
                            r_mosi <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_sclk <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_gap_end) r_cnt <= '0;
                    else           r_cnt <= r_cnt + 16'd1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
